// File: rtl/pc_unit_if.sv
// pc_unit_if: control, fetch-handshake and fault signals between pc_unit and the core
// Optional: `define PC_UNIT_RVC_EN adds the is_compressed signal.
interface pc_unit_if #(parameter int XLEN = 32);
    logic [1:0]      pc_sel;
    logic [XLEN-1:0] branch_offset;
    logic [XLEN-1:0] jump_target;
    logic            stall;
    logic            trap_req;
    logic            fetch_ready;
    logic            fetch_valid;
    logic [XLEN-1:0] pc_out;
    logic [XLEN-1:0] pc_plus4;
    logic            misalign_fault;
    logic [XLEN-1:0] fault_addr;
`ifdef PC_UNIT_RVC_EN
    logic            is_compressed;
`endif

    // pc_unit side: drives the fetch address and fault report
    modport master (
        input  pc_sel, branch_offset, jump_target, stall, trap_req, fetch_ready,
`ifdef PC_UNIT_RVC_EN
        input  is_compressed,
`endif
        output fetch_valid, pc_out, pc_plus4, misalign_fault, fault_addr
    );

    // core / instruction-memory side
    modport slave (
        output pc_sel, branch_offset, jump_target, stall, trap_req, fetch_ready,
`ifdef PC_UNIT_RVC_EN
        output is_compressed,
`endif
        input  fetch_valid, pc_out, pc_plus4, misalign_fault, fault_addr
    );
endinterface

// File: rtl/pc_unit.sv
// pc_unit: RV32I program counter with boot FSM, stall, fetch handshake, trap redirect and misalignment fault
// Optional: `define PC_UNIT_RVC_EN enables 2-byte steps and 2-byte alignment for compressed code.
module pc_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = 'h0000_0100,
    parameter int              BOOT_CYCLES  = 2
) (
    input logic        clk,
    input logic        rst,
    pc_unit_if.master  bus
);
    typedef enum logic [1:0] {BOOT, RUN, TRAP} state_t;

    state_t          state, state_n;
    logic [XLEN-1:0] pc, pc_n, target, step, fault_addr, fault_addr_n;
    logic [3:0]      cnt, cnt_n;
    logic            fault, fault_n, adv, odd, misal, trap;

`ifdef PC_UNIT_RVC_EN
    assign step = bus.is_compressed ? XLEN'(2) : XLEN'(4);
`else
    assign step = XLEN'(4);
`endif

    assign bus.fetch_valid    = state == RUN;
    assign bus.pc_out         = pc;
    assign bus.pc_plus4       = pc + step;
    assign bus.misalign_fault = fault;
    assign bus.fault_addr     = fault_addr;

    // next-PC target selection and redirect conditions
    always_comb begin
        target = bus.pc_sel == 2'b00 ? pc + step :
                 bus.pc_sel == 2'b01 ? pc + bus.branch_offset :
                 bus.pc_sel == 2'b10 ? bus.jump_target :
                                       bus.jump_target & ~XLEN'(1);
`ifdef PC_UNIT_RVC_EN
        odd    = target[0];
`else
        odd    = |target[1:0];
`endif
        adv    = state == RUN && bus.fetch_ready && !bus.stall;
        misal  = adv && bus.pc_sel != 2'b00 && odd;
        trap   = state == RUN && bus.trap_req;
    end

    // next-state logic: trap beats misalignment beats normal advance
    always_comb begin
        state_n      = state;
        pc_n         = pc;
        cnt_n        = cnt;
        fault_n      = 1'b0;
        fault_addr_n = fault_addr;
        if (state == BOOT) begin
            cnt_n = cnt + 4'd1;
            if (cnt == 4'(BOOT_CYCLES - 1)) begin
                state_n = RUN;
                cnt_n   = 4'd0;
            end
        end else if (trap) begin
            state_n = TRAP;
            pc_n    = TRAP_VECTOR;
        end else if (misal) begin
            state_n      = TRAP;
            pc_n         = TRAP_VECTOR;
            fault_n      = 1'b1;
            fault_addr_n = target;
        end else if (adv) begin
            pc_n = target;
        end else if (state == TRAP) begin
            state_n = RUN;
        end
    end

    // state registers with asynchronous reset back to BOOT
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= BOOT;
            pc         <= RESET_VECTOR;
            cnt        <= 4'd0;
            fault      <= 1'b0;
            fault_addr <= '0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            cnt        <= cnt_n;
            fault      <= fault_n;
            fault_addr <= fault_addr_n;
        end
    end
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: scoreboard bench for pc_unit driven by hand-computed directed vectors
module tb_pc_unit;
    typedef struct packed {
        logic        fv;
        logic [31:0] pc;
        logic [31:0] p4;
        logic        mf;
        logic [31:0] fa;
    } exp_t;

`ifdef PC_UNIT_RVC_EN
    localparam logic [31:0] BAD_TGT = 32'h0000_2003;
`else
    localparam logic [31:0] BAD_TGT = 32'h0000_2002;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          tests = 0;
    int          fails = 0;
    int          p4_delta = 4;
    exp_t        q[$];

    pc_unit_if #(.XLEN(32)) bus ();

    pc_unit #(
        .XLEN(32),
        .RESET_VECTOR(32'h0000_0000),
        .TRAP_VECTOR(32'h0000_0100),
        .BOOT_CYCLES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input exp_t e);
        exp_t a;
        a = '{bus.fetch_valid, bus.pc_out, bus.pc_plus4, bus.misalign_fault, bus.fault_addr};
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got fv=%0b pc=%h p4=%h mf=%0b fa=%h, want fv=%0b pc=%h p4=%h mf=%0b fa=%h",
                     name, a.fv, a.pc, a.p4, a.mf, a.fa, e.fv, e.pc, e.p4, e.mf, e.fa);
        end
    endtask

    // monitor: compares the DUT outputs presented each cycle against the scoreboard
    always @(negedge clk) begin
        if (q.size() > 0) check("cycle", q.pop_front());
    end

    task automatic cyc(input logic [1:0] sel, input logic [31:0] off, input logic [31:0] tgt,
                       input logic stl, input logic trp, input logic rdy,
                       input logic fv, input logic [31:0] pc, input logic mf, input logic [31:0] fa);
        bus.pc_sel        = sel;
        bus.branch_offset = off;
        bus.jump_target   = tgt;
        bus.stall         = stl;
        bus.trap_req      = trp;
        bus.fetch_ready   = rdy;
        @(posedge clk);
        q.push_back('{fv, pc, pc + 32'(p4_delta), mf, fa});
        #1;
    endtask

    initial begin
`ifdef PC_UNIT_RVC_EN
        bus.is_compressed = 1'b0;
`endif
        // reset held, trap_req in BOOT ignored
        cyc(2'b00, 0, 0, 0, 1, 1, 0, 32'h0, 0, 32'h0);
        cyc(2'b00, 0, 0, 0, 0, 1, 0, 32'h0, 0, 32'h0);
        rst = 1'b0;
        // boot: two idle cycles then RUN at reset vector
        cyc(2'b00, 0, 0, 0, 0, 1, 0, 32'h0, 0, 32'h0);
        cyc(2'b00, 0, 0, 0, 0, 1, 1, 32'h0, 0, 32'h0);
        cyc(2'b00, 0, 0, 0, 0, 1, 1, 32'h4, 0, 32'h0);
        cyc(2'b00, 0, 0, 0, 0, 1, 1, 32'h8, 0, 32'h0);
        cyc(2'b00, 0, 0, 0, 0, 1, 1, 32'hC, 0, 32'h0);
        // jal to 0x100, then negative branch
        cyc(2'b10, 0, 32'h100, 0, 0, 1, 1, 32'h100, 0, 32'h0);
        cyc(2'b01, 32'hFFFF_FFF8, 0, 0, 0, 1, 1, 32'hF8, 0, 32'h0);
        // stall three cycles, including a misaligned target that must not fault
        cyc(2'b00, 0, 0, 1, 0, 1, 1, 32'hF8, 0, 32'h0);
        cyc(2'b00, 0, 0, 1, 0, 1, 1, 32'hF8, 0, 32'h0);
        cyc(2'b10, 0, 32'h2, 1, 0, 1, 1, 32'hF8, 0, 32'h0);
        // fetch not ready: hold
        cyc(2'b00, 0, 0, 0, 0, 0, 1, 32'hF8, 0, 32'h0);
        // jalr clears bit0
        cyc(2'b11, 0, 32'h2001, 0, 0, 1, 1, 32'h2000, 0, 32'h0);
        // misaligned jal: fault pulse, trap vector, bubble, then RUN
        cyc(2'b10, 0, BAD_TGT, 0, 0, 1, 0, 32'h100, 1, BAD_TGT);
        cyc(2'b00, 0, 0, 0, 0, 1, 1, 32'h100, 0, BAD_TGT);
        cyc(2'b00, 0, 0, 0, 0, 1, 1, 32'h104, 0, BAD_TGT);
        // trap wins over stall and misalignment
        cyc(2'b10, 0, 32'h40, 0, 0, 1, 1, 32'h40, 0, BAD_TGT);
        cyc(2'b10, 0, 32'h3, 1, 1, 1, 0, 32'h100, 0, BAD_TGT);
        cyc(2'b00, 0, 0, 0, 0, 1, 1, 32'h100, 0, BAD_TGT);
        // wrap past all-ones
        cyc(2'b10, 0, 32'hFFFF_FFFC, 0, 0, 1, 1, 32'hFFFF_FFFC, 0, BAD_TGT);
        cyc(2'b00, 0, 0, 0, 0, 1, 1, 32'h0, 0, BAD_TGT);
        // trap with fetch not ready, then async reset in the middle of TRAP
        cyc(2'b00, 0, 0, 0, 1, 0, 0, 32'h100, 0, BAD_TGT);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("async_rst", '{1'b0, 32'h0, 32'h4, 1'b0, 32'h0});
`ifdef PC_UNIT_RVC_EN
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(2'b00, 0, 0, 0, 0, 1, 0, 32'h0, 0, 32'h0);
        cyc(2'b00, 0, 0, 0, 0, 1, 1, 32'h0, 0, 32'h0);
        cyc(2'b10, 0, 32'h10, 0, 0, 1, 1, 32'h10, 0, 32'h0);
        bus.is_compressed = 1'b1;
        p4_delta = 2;
        cyc(2'b00, 0, 0, 0, 0, 1, 1, 32'h12, 0, 32'h0);
        cyc(2'b10, 0, 32'h22, 0, 0, 1, 1, 32'h22, 0, 32'h0);
`endif
        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d entries left, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter unit for the RV32I core; successor to the single-cycle next-PC selector.
- Holds the architectural PC and computes next-PC for sequential, branch, jal and jalr flow.
- Adds stall, fetch handshake, external trap redirect, misaligned-target detection and a boot state machine.
- Sits between decode/execute (PCSel, targets) and the instruction-fetch port.

Parameters:
- XLEN, 32, PC and target width in bits.
- RESET_VECTOR, 32'h0000_0000, PC value loaded at boot.
- TRAP_VECTOR, 32'h0000_0100, PC loaded on trap redirect or misaligned fault.
- BOOT_CYCLES, 2, idle cycles in BOOT before the first fetch (range 1..15).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- pc_sel  in  2  00 PC+4, 01 branch (PC+offset), 10 jal (target), 11 jalr (target with bit0 cleared)
- branch_offset  in  XLEN  signed branch offset
- jump_target  in  XLEN  ALU-computed target for jal/jalr
- stall  in  1  hold PC (hazard unit)
- trap_req  in  1  external trap/exception request
- fetch_ready  in  1  instruction memory accepts the address
- fetch_valid  out  1  pc_out is a valid fetch address
- pc_out  out  XLEN  current PC
- pc_plus4  out  XLEN  pc_out + 4 (link value)
- misalign_fault  out  1  one-cycle pulse: redirect target not 4-byte aligned
- fault_addr  out  XLEN  offending target, held until the next fault

Behaviour:
- Reset (async, any time, including mid-redirect): state=BOOT, pc_out=RESET_VECTOR, fetch_valid=0, misalign_fault=0, fault_addr=0, boot counter=0.
- States:
  - BOOT: counts BOOT_CYCLES cycles, then goes to RUN; fetch_valid=0.
  - RUN: fetch_valid=1.
  - TRAP: single bubble cycle; fetch_valid=0; pc_out already equals TRAP_VECTOR; goes to RUN the next cycle.
- Advance condition in RUN: adv = fetch_ready & ~stall. When adv=0, pc_out holds and sequential/branch inputs are ignored.
- Next-PC target by pc_sel:
  - 00: pc_out+4
  - 01: pc_out+branch_offset
  - 10: jump_target
  - 11: jump_target & ~1
  - All arithmetic is modulo 2^XLEN; wrap past all-ones is silent.
- Misalignment check: target[1:0]!=0 with pc_sel!=00 and adv=1 gives:
  - misalign_fault pulse the next cycle,
  - fault_addr <= target,
  - pc_out <= TRAP_VECTOR,
  - state -> TRAP.
- Priority (highest first): rst > trap_req > misalignment > normal update.
  - trap_req in RUN redirects regardless of stall/fetch_ready: pc_out <= TRAP_VECTOR, state -> TRAP.
  - trap_req in BOOT or TRAP is ignored.
  - trap_req and a misaligned target in the same cycle: trap wins, no misalign_fault.
- Latency: next-PC is visible on pc_out one clock after the advancing edge.
- pc_plus4 is combinational from pc_out.
- No combinational path from fetch_ready to pc_out.

Optional Feature:
- Macro: PC_UNIT_RVC_EN.
- Defined:
  - Adds input is_compressed (1 bit).
  - pc_sel=00 advances by 2 when is_compressed=1.
  - pc_plus4 becomes pc_out+2 when is_compressed=1.
  - Misalignment check uses target[0] only; with jalr clearing bit0, jalr never faults.
- Undefined:
  - Port absent.
  - Always +4; 4-byte alignment check as above.

Test Plan:
- Reset then release, BOOT_CYCLES=2 -> fetch_valid=0 for 2 cycles, then 1 with pc_out=0x0; with pc_sel=00 and fetch_ready=1, pc_out steps 0x4, 0x8, 0xC.
- pc_out=0x100, pc_sel=01, branch_offset=0xFFFFFFF8 -> pc_out=0xF8 next cycle; stall=1 for 3 cycles -> pc_out held at 0xF8; fetch_ready=0 -> held.
- pc_sel=11, jump_target=0x2001 -> pc_out=0x2000, no fault; pc_sel=10, jump_target=0x2002 -> misalign_fault pulse, fault_addr=0x2002, pc_out=0x100, one cycle with fetch_valid=0, then RUN.
- trap_req=1 together with stall=1 and pc_sel=10, jump_target=0x3 at pc_out=0x40 -> pc_out=0x100, misalign_fault stays 0, TRAP bubble.
- pc_out=0xFFFFFFFC, pc_sel=00 -> pc_out=0x0 (wrap); assert rst mid-TRAP -> immediate pc_out=RESET_VECTOR, fetch_valid=0.
- PC_UNIT_RVC_EN defined: is_compressed=1 at 0x10 -> pc_out=0x12, pc_plus4=0x14; pc_sel=10, jump_target=0x22 -> no fault.
